vga_draw_arbiter: RTL and testbench
===================================

# vga_draw_arbiter

Job-level scheduler that shares the single 160x120 VGA adapter plot port between several drawing engines (fillscreen, circle, reuleaux and later ones). It takes per-engine draw requests, grants them one at a time in round-robin order, drives the granted engine's start/done handshake, and forwards only that engine's pixel stream to the adapter. It sits between the engines and `vga_adapter` in the task top levels, replacing direct engine-to-adapter wiring.

## Interface
- `NCLIENT`, 3: number of drawing engines, 2..8.
- `WDOG_W`, 16: watchdog counter width; used only with the watchdog macro.

- `clk`  in  1  system clock (CLOCK_50).
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  NCLIENT  level request per engine; sampled only in IDLE.
- `eng_start`  out  NCLIENT  start level to each engine; at most one bit high.
- `eng_done`  in  NCLIENT  done level from each engine.
- `eng_x`  in  NCLIENT*8  packed engine x, client i at [8i+7:8i].
- `eng_y`  in  NCLIENT*7  packed engine y.
- `eng_colour`  in  NCLIENT*3  packed engine colour.
- `eng_plot`  in  NCLIENT  engine plot strobes.
- `ack`  out  NCLIENT  one-cycle pulse when that client's job finishes.
- `busy`  out  1  high in every state except IDLE.
- `err`  out  1  sticky watchdog abort flag.
- `vga_x` / `vga_y` / `vga_colour` / `vga_plot`  out  8/7/3/1  registered adapter drive.

## Operation
- States: IDLE, RUN, RELEASE.
- IDLE: if `req` nonzero, select the first set bit searching upward from `last+1` (wrapping); latch `gnt`, update `last`, go RUN. Otherwise stay.
- RUN: `eng_start[gnt]`=1. When `eng_done[gnt]`=1, go RELEASE.
- RELEASE: all `eng_start`=0, `ack[gnt]`=1 for this single cycle, then IDLE.
- `req` deassertion during RUN does not abort the job. `eng_done` of non-granted clients is ignored.
- Pixel path: in RUN, register granted engine's x/y/colour/plot; `vga_plot` = `eng_plot[gnt]` AND x<160 AND y<120 (off-screen pixels are dropped). Outside RUN, `vga_plot`=0; x/y/colour hold their last values.
- Reset values: state IDLE, `last`=NCLIENT-1 (client 0 has first priority), `eng_start`=0, `ack`=0, `busy`=0, `err`=0, `vga_*`=0.
- Async reset mid-job drops `eng_start` immediately; engines reset on the same `rst_n`.

## Timing
- `req` high in IDLE at edge T -> `eng_start[g]` high and `busy` high after edge T+1.
- Engine plot at edge k -> `vga_plot` at k+1. Fixed 1-cycle latency, no bubbles.
- `eng_done` seen at edge D -> RELEASE after D+1 (`ack` pulse, start low) -> IDLE after D+2. The next grant is visible after D+3. Minimum 3-cycle gap between jobs.
- Simultaneous requests: strict round-robin. With all requesting, the grant order is 0,1,2,0,...
- A single persistent requester is re-granted back-to-back, with the 3-cycle gap.

## Configuration
- `VGA_ARB_WATCHDOG_EN` defined:
  - A `WDOG_W`-bit counter clears on entry to RUN and increments each RUN cycle.
  - At all-ones the job is aborted: go RELEASE, `ack` still pulses, and `err` sets and stays until reset.
- Undefined: no counter, and `err` is tied 0.

## Structure
- Package `vga_arb_pkg`:
  - state enum `arb_state_t`;
  - `SCREEN_W`=160 and `SCREEN_H`=120;
  - `X_W`=8, `Y_W`=7, `C_W`=3.
- Sub-module `rr_pick`: combinational round-robin picker. Inputs are `req` and `last`; outputs are `valid` and `idx`.

## Test plan
- Reset, then `req`=3'b001: `eng_start`=001 one cycle later; engine plots (5,7,colour 3) -> `vga_x`=5, `vga_y`=7, `vga_colour`=3, `vga_plot`=1 the next cycle; `done` -> `ack`=001 pulse, `busy` low 2 cycles later.
- `req`=3'b111 held for three jobs: grants occur in order 0,1,2, with exactly 3 idle cycles between `done` and the next `eng_start`.
- Granted engine plots x=160,y=10 and x=20,y=120: `vga_plot` stays 0. x=159,y=119: `vga_plot`=1.
- Non-granted engine 2 asserts plot and done while client 1 runs: no effect on `vga_*` or the state.
- Assert `rst_n`=0 mid-RUN: `eng_start`, `busy`, `vga_plot` go 0 without a clock edge; after release, `req`=3'b110 grants client 1 first.
- With `VGA_ARB_WATCHDOG_EN`, `WDOG_W`=4, engine never asserts done: abort after 15 RUN cycles, `ack` pulses, `err`=1 and stays until reset.

Source files
------------

// File: rtl/vga_arb_pkg.sv
// Shared types and constants for the VGA draw arbiter.
package vga_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_t;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int C_W      = 3;

    // True when the pixel lies inside the visible 160x120 area.
    function automatic logic on_screen(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        return (x < X_W'(SCREEN_W)) && (y < Y_W'(SCREEN_H));
    endfunction

endpackage

// File: rtl/vga_draw_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester strictly after `last`, wrapping.
module rr_pick #(
    parameter int NCLIENT = 3,
    parameter int IDX_W   = $clog2(NCLIENT)
) (
    input  logic [NCLIENT-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        int unsigned cand;
        valid = |req;
        idx   = last;
        cand  = 0;
        for (int unsigned off = NCLIENT; off >= 1; off--) begin
            cand = (32'(last) + off) % NCLIENT;
            if (req[cand]) begin
                idx = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/vga_draw_arbiter.sv
// Job-level round-robin arbiter sharing the VGA adapter plot port between drawing engines.
// Optional abort watchdog enabled by defining VGA_ARB_WATCHDOG_EN.
module vga_draw_arbiter
    import vga_arb_pkg::*;
#(
    parameter int NCLIENT = 3,
    parameter int WDOG_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NCLIENT-1:0]     req,
    output logic [NCLIENT-1:0]     eng_start,
    input  logic [NCLIENT-1:0]     eng_done,
    input  logic [NCLIENT*X_W-1:0] eng_x,
    input  logic [NCLIENT*Y_W-1:0] eng_y,
    input  logic [NCLIENT*C_W-1:0] eng_colour,
    input  logic [NCLIENT-1:0]     eng_plot,
    output logic [NCLIENT-1:0]     ack,
    output logic                   busy,
    output logic                   err,
    output logic [X_W-1:0]         vga_x,
    output logic [Y_W-1:0]         vga_y,
    output logic [C_W-1:0]         vga_colour,
    output logic                   vga_plot
);

    localparam int IDX_W = $clog2(NCLIENT);

    arb_state_t          state_q;
    logic [IDX_W-1:0]    gnt_q;
    logic [IDX_W-1:0]    last_q;
    logic [NCLIENT-1:0]  start_q;
    logic [NCLIENT-1:0]  ack_q;
    logic [X_W-1:0]      vga_x_q;
    logic [Y_W-1:0]      vga_y_q;
    logic [C_W-1:0]      vga_colour_q;
    logic                vga_plot_q;

    logic                pick_valid;
    logic [IDX_W-1:0]    pick_idx;
    logic [NCLIENT-1:0]  pick_oh;
    logic [NCLIENT-1:0]  gnt_oh;
    logic [X_W-1:0]      sel_x;
    logic [Y_W-1:0]      sel_y;
    logic [C_W-1:0]      sel_colour;
    logic                sel_plot;
    logic                sel_done;
    logic                wdog_expire;

    rr_pick #(
        .NCLIENT (NCLIENT),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req   (req),
        .last  (last_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // One-hot forms of the pending pick and the current grant.
    always_comb begin
        pick_oh = '0;
        gnt_oh  = '0;
        for (int unsigned i = 0; i < NCLIENT; i++) begin
            pick_oh[i] = (IDX_W'(i) == pick_idx);
            gnt_oh[i]  = (IDX_W'(i) == gnt_q);
        end
    end

    // Select the granted engine's pixel and done; other engines are ignored.
    always_comb begin
        sel_x      = '0;
        sel_y      = '0;
        sel_colour = '0;
        sel_plot   = 1'b0;
        sel_done   = 1'b0;
        for (int unsigned i = 0; i < NCLIENT; i++) begin
            if (gnt_oh[i]) begin
                sel_x      = eng_x[i*X_W +: X_W];
                sel_y      = eng_y[i*Y_W +: Y_W];
                sel_colour = eng_colour[i*C_W +: C_W];
                sel_plot   = eng_plot[i];
                sel_done   = eng_done[i];
            end
        end
    end

`ifdef VGA_ARB_WATCHDOG_EN
    logic [WDOG_W-1:0] wdog_q;
    logic [WDOG_W-1:0] wdog_d;
    logic              err_q;

    assign wdog_d      = wdog_q + 1'b1;
    assign wdog_expire = (state_q == ST_RUN) && (wdog_d == '1);
    assign err         = err_q;

    // Job watchdog: cleared while idle so every RUN starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= '0;
        end else if (state_q == ST_RUN) begin
            wdog_q <= wdog_d;
        end else begin
            wdog_q <= '0;
        end
    end
`else
    assign wdog_expire = 1'b0;
    // No watchdog: err is constant low; WDOG_W is referenced so it stays part of the interface.
    assign err         = (WDOG_W < 0);
`endif

    // Arbitration FSM with registered start/ack and the registered adapter drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            gnt_q        <= '0;
            last_q       <= IDX_W'(NCLIENT - 1);
            start_q      <= '0;
            ack_q        <= '0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
`ifdef VGA_ARB_WATCHDOG_EN
            err_q        <= 1'b0;
`endif
        end else begin
            ack_q      <= '0;
            vga_plot_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        gnt_q   <= pick_idx;
                        last_q  <= pick_idx;
                        start_q <= pick_oh;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    vga_x_q      <= sel_x;
                    vga_y_q      <= sel_y;
                    vga_colour_q <= sel_colour;
                    vga_plot_q   <= sel_plot && on_screen(sel_x, sel_y);
                    if (sel_done || wdog_expire) begin
                        start_q <= '0;
                        ack_q   <= gnt_oh;
                        state_q <= ST_RELEASE;
`ifdef VGA_ARB_WATCHDOG_EN
                        if (!sel_done) begin
                            err_q <= 1'b1;
                        end
`endif
                    end
                end
                ST_RELEASE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign eng_start  = start_q;
    assign ack        = ack_q;
    assign busy       = (state_q != ST_IDLE);
    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign vga_plot   = vga_plot_q;

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Scoreboard bench for vga_draw_arbiter: directed cases plus randomized rounds.
// Watchdog abort case is exercised when VGA_ARB_WATCHDOG_EN is defined.
module tb_vga_draw_arbiter;

    localparam int N    = 3;
    localparam int WDOG = 4;

    logic           clk        = 1'b0;
    logic           rst_n      = 1'b0;
    logic [N-1:0]   req        = '0;
    logic [N-1:0]   eng_done   = '0;
    logic [N-1:0]   eng_plot   = '0;
    logic [N*8-1:0] eng_x      = '0;
    logic [N*7-1:0] eng_y      = '0;
    logic [N*3-1:0] eng_colour = '0;
    logic [N-1:0]   eng_start;
    logic [N-1:0]   ack;
    logic           busy;
    logic           err;
    logic [7:0]     vga_x;
    logic [6:0]     vga_y;
    logic [2:0]     vga_colour;
    logic           vga_plot;

    always #5 clk = ~clk;

    vga_draw_arbiter #(
        .NCLIENT (N),
        .WDOG_W  (WDOG)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .eng_start  (eng_start),
        .eng_done   (eng_done),
        .eng_x      (eng_x),
        .eng_y      (eng_y),
        .eng_colour (eng_colour),
        .eng_plot   (eng_plot),
        .ack        (ack),
        .busy       (busy),
        .err        (err),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot)
    );

    typedef struct { int x; int y; int c; } pix_t;

    pix_t pq[$];
    int   gq[$];
    int   aq[$];
    int   checks   = 0;
    int   failures = 0;
    int   m_last   = N - 1;
    int   rem[N];
    bit   act[N];
    bit   gap[N];
    bit   auto_eng = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        failures++;
        $display("FAIL %s: DUT produced an event with nothing expected", name);
    endtask

    // Reference round-robin: first requester after `last`, wrapping.
    function automatic int rr_next(input int last, input logic [N-1:0] mask);
        for (int k = 1; k <= N; k++) begin
            if (mask[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    // Behavioural engines: granted one plots a few pixels then holds done; others emit noise.
    task automatic eng_step();
        int xv, yv, cv;
        for (int i = 0; i < N; i++) begin
            xv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(150, 255)) : int'($urandom_range(0, 159));
            yv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(112, 127)) : int'($urandom_range(0, 119));
            cv = int'($urandom_range(0, 7));
            eng_x[i*8 +: 8]      = 8'(xv);
            eng_y[i*7 +: 7]      = 7'(yv);
            eng_colour[i*3 +: 3] = 3'(cv);
            if (eng_start[i]) begin
                if (!act[i]) begin
                    act[i] = 1'b1;
                    rem[i] = int'($urandom_range(0, 4));
                    gap[i] = 1'b0;
                end
                eng_done[i] = 1'b0;
                eng_plot[i] = 1'b0;
                if (rem[i] > 0 && (gap[i] || $urandom_range(0, 2) != 0)) begin
                    eng_plot[i] = 1'b1;
                    rem[i]--;
                    gap[i] = 1'b0;
                    if (xv < 160 && yv < 120) pq.push_back('{xv, yv, cv});
                end else if (rem[i] > 0) begin
                    gap[i] = 1'b1;
                end else begin
                    eng_done[i] = 1'b1;
                end
            end else begin
                act[i]      = 1'b0;
                eng_plot[i] = 1'($urandom_range(0, 1));
                eng_done[i] = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_eng) eng_step();
    endtask

    task automatic do_reset();
        auto_eng = 1'b0;
        rst_n    = 1'b0;
        req      = '0;
        eng_done = '0;
        eng_plot = '0;
        pq.delete();
        gq.delete();
        aq.delete();
        m_last = N - 1;
        for (int i = 0; i < N; i++) act[i] = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Monitor: pops expectations whenever the DUT presents a grant, an ack or a pixel.
    initial begin : monitor
        logic [N-1:0] prev_start;
        int   g;
        pix_t p;
        prev_start = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (eng_start != '0 && prev_start == '0) begin
                    if (gq.size() == 0) unexpected("grant");
                    else begin
                        g = gq.pop_front();
                        chk("grant", 32'(eng_start), 32'(1 << g));
                    end
                end
                if (ack != '0) begin
                    if (aq.size() == 0) unexpected("ack");
                    else begin
                        g = aq.pop_front();
                        chk("ack", 32'(ack), 32'(1 << g));
                    end
                end
                if (vga_plot) begin
                    if (pq.size() == 0) unexpected("pixel");
                    else begin
                        p = pq.pop_front();
                        chk("pix_x", 32'(vga_x), 32'(p.x));
                        chk("pix_y", 32'(vga_y), 32'(p.y));
                        chk("pix_c", 32'(vga_colour), 32'(p.c));
                    end
                end
                chk("busy_vs_handshake", 32'(busy), 32'((eng_start != '0) || (ack != '0)));
                chk("start_onehot", 32'($countones(eng_start) <= 1), 32'(1));
            end
            prev_start = eng_start;
        end
    end

    initial begin : timeout
        #(5_000_000);
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int           g;
        int           jobs, seen, budget;
        logic [N-1:0] mask;
        int           bx[3];
        int           by[3];
        int           bp[3];
        bx = '{160, 20, 159};
        by = '{10, 120, 119};
        bp = '{0, 0, 1};

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_start", 32'(eng_start), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_vga_plot", 32'(vga_plot), 0);
        chk("rst_vga_xyc", {vga_x, vga_y, vga_colour}, 0);
        rst_n = 1'b1;

        // Single job on client 0 with one pixel
        req = 3'b001;
        m_last = rr_next(m_last, req);
        gq.push_back(m_last);
        aq.push_back(m_last);
        tick();
        chk("t1_start", 32'(eng_start), 32'b001);
        chk("t1_busy", 32'(busy), 1);
        req = '0;
        eng_x[7:0] = 8'd5;
        eng_y[6:0] = 7'd7;
        eng_colour[2:0] = 3'd3;
        eng_plot = 3'b001;
        pq.push_back('{5, 7, 3});
        tick();
        chk("t1_vga_x", 32'(vga_x), 5);
        chk("t1_vga_y", 32'(vga_y), 7);
        chk("t1_vga_c", 32'(vga_colour), 3);
        chk("t1_vga_plot", 32'(vga_plot), 1);
        eng_plot = '0;
        eng_done = 3'b001;
        tick();
        chk("t1_ack", 32'(ack), 32'b001);
        chk("t1_start_low", 32'(eng_start), 0);
        chk("t1_busy_release", 32'(busy), 1);
        chk("t1_plot_off", 32'(vga_plot), 0);
        eng_done = '0;
        tick();
        chk("t1_ack_pulse", 32'(ack), 0);
        chk("t1_busy_idle", 32'(busy), 0);

        // Client 1 runs: screen-boundary pixels, with client 2 plotting and signalling done
        req = 3'b010;
        m_last = rr_next(m_last, req);
        gq.push_back(m_last);
        aq.push_back(m_last);
        tick();
        chk("t3_start", 32'(eng_start), 32'b010);
        req = '0;
        for (int k = 0; k < 3; k++) begin
            eng_x[15:8]  = 8'(bx[k]);
            eng_y[13:7]  = 7'(by[k]);
            eng_colour[5:3] = 3'd6;
            eng_x[23:16] = 8'd33;
            eng_y[20:14] = 7'd44;
            eng_plot     = 3'b110;
            eng_done     = 3'b100;
            if (bp[k] != 0) pq.push_back('{bx[k], by[k], 6});
            tick();
            chk("bound_plot", 32'(vga_plot), 32'(bp[k]));
            chk("alien_start", 32'(eng_start), 32'b010);
            chk("alien_ack", 32'(ack), 0);
        end
        eng_plot = 3'b100;
        tick();
        chk("alien_plot", 32'(vga_plot), 0);
        chk("alien_x", 32'(vga_x), 159);
        chk("alien_hold", 32'(eng_start), 32'b010);
        eng_plot = '0;
        eng_done = 3'b010;
        tick();
        chk("t3_ack", 32'(ack), 32'b010);
        eng_done = '0;
        tick();
        tick();

        // Async reset in the middle of a job
        req = 3'b001;
        m_last = rr_next(m_last, req);
        gq.push_back(m_last);
        tick();
        chk("t5_start", 32'(eng_start), 32'b001);
        req = '0;
        eng_x[7:0] = 8'd10;
        eng_y[6:0] = 7'd20;
        eng_plot = 3'b001;
        tick();
        chk("t5_plot_before", 32'(vga_plot), 1);
        #1;
        rst_n = 1'b0;
        eng_plot = '0;
        pq.delete();
        gq.delete();
        aq.delete();
        m_last = N - 1;
        #1;
        chk("t5_rst_start", 32'(eng_start), 0);
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_plot", 32'(vga_plot), 0);
        tick();
        rst_n = 1'b1;
        req = 3'b110;
        m_last = rr_next(m_last, req);
        gq.push_back(m_last);
        aq.push_back(m_last);
        tick();
        chk("t5_first_grant", 32'(eng_start), 32'b010);
        req = '0;
        eng_done = 3'b010;
        tick();
        chk("t5_ack", 32'(ack), 32'b010);
        eng_done = '0;
        tick();
        tick();

        // All clients requesting from reset: grants 0,1,2 with a 3-cycle gap
        do_reset();
        req = 3'b111;
        for (int j = 0; j < 3; j++) begin
            m_last = rr_next(m_last, req);
            gq.push_back(m_last);
            aq.push_back(m_last);
        end
        tick();
        chk("rr_first", 32'(eng_start), 32'b001);
        for (int j = 0; j < 3; j++) begin
            eng_done = N'(1 << j);
            tick();
            chk("rr_ack", 32'(ack), 32'(1 << j));
            chk("rr_gap1", 32'(eng_start), 0);
            eng_done = '0;
            if (j == 2) req = '0;
            tick();
            chk("rr_gap2", 32'(eng_start), 0);
            tick();
            chk("rr_next_start", 32'(eng_start), (j < 2) ? 32'(1 << (j + 1)) : 32'(0));
        end
        chk("rr_idle", 32'(busy), 0);

        // Randomized rounds with a fixed request mask per round
        auto_eng = 1'b1;
        for (int r = 0; r < 16; r++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            jobs = int'($urandom_range(1, 4));
            seen = 0;
            budget = 0;
            for (int j = 0; j < jobs; j++) begin
                m_last = rr_next(m_last, mask);
                gq.push_back(m_last);
                aq.push_back(m_last);
            end
            req = mask;
            while (seen < jobs && budget < 60 * jobs) begin
                tick();
                budget++;
                if (ack != '0) begin
                    seen++;
                    if (seen == jobs) req = '0;
                end
            end
            chk("round_jobs_done", 32'(seen), 32'(jobs));
            repeat ($urandom_range(0, 3)) tick();
        end
        auto_eng = 1'b0;
        eng_done = '0;
        eng_plot = '0;
        tick();
        tick();
        chk("random_idle", 32'(busy), 0);
        chk("queues_drained", 32'(pq.size() + gq.size() + aq.size()), 0);

`ifdef VGA_ARB_WATCHDOG_EN
        // Engine never finishes: abort after 15 RUN cycles, err sticks until reset
        req = 3'b001;
        m_last = rr_next(m_last, req);
        gq.push_back(m_last);
        aq.push_back(m_last);
        tick();
        chk("wd_start", 32'(eng_start), 32'b001);
        req = '0;
        repeat (14) tick();
        chk("wd_still_running", 32'(eng_start), 32'b001);
        chk("wd_err_before", 32'(err), 0);
        tick();
        chk("wd_ack", 32'(ack), 32'b001);
        chk("wd_err_set", 32'(err), 1);
        repeat (5) tick();
        chk("wd_err_sticky", 32'(err), 1);
        do_reset();
        chk("wd_err_cleared", 32'(err), 0);
`else
        chk("err_low", 32'(err), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
